// File: rtl/display_pkg.sv
// Shared video definitions: pattern mode encodings and colour constants used by
// the test pattern generator and later display stages.
package display_pkg;

  typedef enum logic [1:0] {
    ModeBars      = 2'd0,
    ModeChecker   = 2'd1,
    ModeGradient  = 2'd2,
    ModeMovingBar = 2'd3
  } pattern_mode_e;

  localparam logic [23:0] ColWhite   = 24'hFFFFFF;
  localparam logic [23:0] ColYellow  = 24'hFFFF00;
  localparam logic [23:0] ColCyan    = 24'h00FFFF;
  localparam logic [23:0] ColGreen   = 24'h00FF00;
  localparam logic [23:0] ColMagenta = 24'hFF00FF;
  localparam logic [23:0] ColRed     = 24'hFF0000;
  localparam logic [23:0] ColBlue    = 24'h0000FF;
  localparam logic [23:0] ColBlack   = 24'h000000;

  localparam logic [23:0] CheckerOn   = ColWhite;
  localparam logic [23:0] CheckerOff  = ColBlack;
  localparam logic [23:0] MovingBarFg = ColWhite;
  localparam logic [23:0] MovingBarBg = 24'h000040;

  // Colour-bar palette, index 0 at the left edge of the screen.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] col;
    case (idx)
      3'd0:    col = ColWhite;
      3'd1:    col = ColYellow;
      3'd2:    col = ColCyan;
      3'd3:    col = ColGreen;
      3'd4:    col = ColMagenta;
      3'd5:    col = ColRed;
      3'd6:    col = ColBlue;
      default: col = ColBlack;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/test_pattern_gen_if.sv
// Pixel-stream bundle between the display timing stage and the pattern generator.
interface test_pattern_gen_if;

  logic        [2:0]  i_hve;
  logic signed [12:0] i_x;
  logic signed [12:0] i_y;
  logic        [1:0]  i_mode;
  logic        [2:0]  o_hve;
  logic        [23:0] o_rgb;
  logic        [15:0] o_frame;

  modport master (
    output i_hve, i_x, i_y, i_mode,
    input  o_hve, o_rgb, o_frame
  );

  modport slave (
    input  i_hve, i_x, i_y, i_mode,
    output o_hve, o_rgb, o_frame
  );

endinterface

// File: rtl/bar_counter.sv
// Colour-bar index tracker: counts pixels within the current bar and steps the
// bar index every BAR_W pixels, saturating on the last bar.
module bar_counter #(
  parameter int BAR_W = 160
) (
  input  logic       i_pixel_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_advance,
  output logic [2:0] o_index
);

  logic [12:0] cnt_q, cnt_d, cnt_cur;
  logic [2:0]  idx_q, idx_d, idx_cur;

  // State holds the position of the next pixel; clear overrides it so the
  // line-start pixel is always bar 0.
  always_comb begin
    cnt_cur = i_clear ? 13'd0 : cnt_q;
    idx_cur = i_clear ? 3'd0 : idx_q;
    cnt_d   = cnt_cur;
    idx_d   = idx_cur;
    if (i_advance && idx_cur != 3'd7) begin
      if (cnt_cur == 13'(BAR_W - 1)) begin
        cnt_d = 13'd0;
        idx_d = idx_cur + 3'd1;
      end else begin
        cnt_d = cnt_cur + 13'd1;
      end
    end
  end

  always_ff @(posedge i_pixel_clk) begin
    if (!i_rst_n) begin
      cnt_q <= 13'd0;
      idx_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign o_index = idx_cur;

endmodule

// File: rtl/test_pattern_gen.sv
// Test pattern generator: renders colour bars, checkerboard, gradient or a moving
// bar from the incoming pixel coordinates with a fixed 2-cycle latency.
module test_pattern_gen
  import display_pkg::*;
#(
  parameter int         H_RESOLUTION = 1280,
  parameter int         V_RESOLUTION = 1024,
  parameter int         BAR_STEP     = 4,
  parameter logic [2:0] HVE_IDLE     = 3'b011
) (
  input logic               i_pixel_clk,
  input logic               i_rst_n,
  test_pattern_gen_if.slave bus
);

  localparam int                 BarW    = H_RESOLUTION / 8;
  localparam logic signed [12:0] HRes    = 13'(H_RESOLUTION);
  localparam logic signed [12:0] VRes    = 13'(V_RESOLUTION);
  localparam logic signed [12:0] BarStep = 13'(BAR_STEP);

  pattern_mode_e      mode_q, mode_d;
  logic [15:0]        frame_q, frame_d;
  logic signed [12:0] bar_x_q, bar_x_d, bar_sum;
  logic [2:0]         hve_s1_q, hve_q;
  logic [23:0]        rgb_s1_d, rgb_s1_q, rgb_q;
  logic               frame_start, in_view;
  logic [2:0]         bar_idx;

  assign frame_start = bus.i_hve[2] && (bus.i_x == 13'sd0) && (bus.i_y == 13'sd0);

  bar_counter #(
    .BAR_W (BarW)
  ) u_bar_counter (
    .i_pixel_clk (i_pixel_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (bus.i_x == 13'sd0),
    .i_advance   (!bus.i_x[12]),
    .o_index     (bar_idx)
  );

  // Next-state values double as the render state so the frame-start pixel
  // already uses the new mode, frame count and bar position.
  always_comb begin
    bar_sum = bar_x_q + BarStep;
    mode_d  = mode_q;
    frame_d = frame_q;
    bar_x_d = bar_x_q;
    if (frame_start) begin
      mode_d  = pattern_mode_e'(bus.i_mode);
      frame_d = frame_q + 16'd1;
      bar_x_d = (bar_sum >= HRes) ? (bar_sum - HRes) : bar_sum;
    end
  end

  always_comb begin
    in_view  = !bus.i_x[12] && !bus.i_y[12] && (bus.i_x < HRes) && (bus.i_y < VRes);
    rgb_s1_d = ColBlack;
    if (bus.i_hve[2] && in_view) begin
      unique case (mode_d)
        ModeBars:      rgb_s1_d = bar_colour(bar_idx);
        ModeChecker:   rgb_s1_d = (bus.i_x[5] ^ bus.i_y[5]) ? CheckerOn : CheckerOff;
        ModeGradient:  rgb_s1_d = {bus.i_x[7:0], bus.i_y[7:0], frame_d[7:0]};
        ModeMovingBar: rgb_s1_d = (bus.i_x >= bar_x_d && bus.i_x < bar_x_d + 13'sd16) ?
                                  MovingBarFg : MovingBarBg;
        default:       rgb_s1_d = ColBlack;
      endcase
    end
  end

  always_ff @(posedge i_pixel_clk) begin
    if (!i_rst_n) begin
      mode_q   <= ModeBars;
      frame_q  <= 16'd0;
      bar_x_q  <= 13'sd0;
      hve_s1_q <= HVE_IDLE;
      rgb_s1_q <= ColBlack;
      hve_q    <= HVE_IDLE;
      rgb_q    <= ColBlack;
    end else begin
      mode_q   <= mode_d;
      frame_q  <= frame_d;
      bar_x_q  <= bar_x_d;
      hve_s1_q <= bus.i_hve;
      rgb_s1_q <= rgb_s1_d;
      hve_q    <= hve_s1_q;
      rgb_q    <= rgb_s1_q;
    end
  end

  assign bus.o_hve   = hve_q;
  assign bus.o_rgb   = rgb_q;
  assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen at 1280x1024 with hand-computed pixels.
module tb_test_pattern_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  test_pattern_gen_if bus ();

  test_pattern_gen #(
    .H_RESOLUTION (1280),
    .V_RESOLUTION (1024),
    .BAR_STEP     (4),
    .HVE_IDLE     (3'b011)
  ) dut (
    .i_pixel_clk (clk),
    .i_rst_n     (rst_n),
    .bus         (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [2:0]  obs_hve;
  logic [23:0] obs_rgb;
  logic [15:0] obs_frame;
  logic [23:0] blank_or;
  logic [23:0] line_rgb [1280];
  logic [2:0]  line_hve [1280];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs read here belong to the inputs driven two calls earlier.
  task automatic cycle(input logic [2:0] hve, input int x, input int y, input logic [1:0] mode);
    @(posedge clk);
    #1;
    obs_hve   = bus.o_hve;
    obs_rgb   = bus.o_rgb;
    obs_frame = bus.o_frame;
    bus.i_hve  = hve;
    bus.i_x    = 13'(x);
    bus.i_y    = 13'(y);
    bus.i_mode = mode;
  endtask

  task automatic sweep_line(input int y, input logic [1:0] mode_lo, input logic [1:0] mode_hi,
                            input int sw_x);
    blank_or = '0;
    for (int x = -4; x < 1282; x++) begin
      int xo;
      xo = x - 2;
      cycle((x >= 0 && x < 1280) ? 3'b100 : 3'b001, x, y, (x < sw_x) ? mode_lo : mode_hi);
      if (xo >= 0) begin
        line_rgb[xo] = obs_rgb;
        line_hve[xo] = obs_hve;
      end else if (xo >= -4) begin
        blank_or |= obs_rgb;
      end
    end
  endtask

  task automatic frame_pulse(input logic [1:0] mode);
    cycle(3'b100, 0, 0, mode);
    cycle(3'b100, 1, 0, mode);
    cycle(3'b001, -4, 0, mode);
  endtask

  initial begin
    bus.i_hve  = 3'b000;
    bus.i_x    = -13'sd20;
    bus.i_y    = -13'sd5;
    bus.i_mode = 2'd0;

    // Reset state
    repeat (3) cycle(3'b000, -20, -5, 2'd0);
    check_eq("rst hve", 32'(obs_hve), 32'h3);
    check_eq("rst rgb", 32'(obs_rgb), 32'h0);
    check_eq("rst frame", 32'(obs_frame), 32'h0);
    rst_n = 1'b1;

    // hve latency
    cycle(3'b001, -20, -5, 2'd0);
    check_eq("release hve", 32'(obs_hve), 32'h3);
    cycle(3'b010, -19, -5, 2'd0);
    cycle(3'b001, -18, -5, 2'd0);
    check_eq("lat hve a", 32'(obs_hve), 32'h1);
    cycle(3'b001, -17, -5, 2'd0);
    check_eq("lat hve b", 32'(obs_hve), 32'h2);
    cycle(3'b001, -16, -5, 2'd0);
    check_eq("lat hve c", 32'(obs_hve), 32'h1);

    // Frame 1, colour bars
    sweep_line(0, 2'd0, 2'd0, 0);
    check_eq("bars x0", 32'(line_rgb[0]), 32'hFFFFFF);
    check_eq("bars x159", 32'(line_rgb[159]), 32'hFFFFFF);
    check_eq("bars x160", 32'(line_rgb[160]), 32'hFFFF00);
    check_eq("bars x480", 32'(line_rgb[480]), 32'h00FF00);
    check_eq("bars x800", 32'(line_rgb[800]), 32'hFF0000);
    check_eq("bars x1279", 32'(line_rgb[1279]), 32'h000000);
    check_eq("bars hve", 32'(line_hve[5]), 32'h4);
    check_eq("bars blank", 32'(blank_or), 32'h0);
    check_eq("frame 1", 32'(obs_frame), 32'd1);

    // Mode request changes mid-frame: still bars
    sweep_line(500, 2'd0, 2'd1, 640);
    check_eq("midchg x640", 32'(line_rgb[640]), 32'hFF00FF);
    check_eq("midchg x700", 32'(line_rgb[700]), 32'hFF00FF);

    // Frame 2, checkerboard
    sweep_line(0, 2'd1, 2'd1, 0);
    check_eq("chk 0,0", 32'(line_rgb[0]), 32'h000000);
    check_eq("chk 32,0", 32'(line_rgb[32]), 32'hFFFFFF);
    check_eq("chk 64,0", 32'(line_rgb[64]), 32'h000000);
    check_eq("frame 2", 32'(obs_frame), 32'd2);
    sweep_line(32, 2'd1, 2'd1, 0);
    check_eq("chk 32,32", 32'(line_rgb[32]), 32'h000000);
    check_eq("chk 0,32", 32'(line_rgb[0]), 32'hFFFFFF);

    // Frame 3, gradient
    sweep_line(0, 2'd2, 2'd2, 0);
    check_eq("grad 0,0", 32'(line_rgb[0]), 32'h000003);
    check_eq("grad 300,0", 32'(line_rgb[300]), 32'h2C0003);
    sweep_line(5, 2'd2, 2'd2, 0);
    check_eq("grad 300,5", 32'(line_rgb[300]), 32'h2C0503);
    check_eq("frame 3", 32'(obs_frame), 32'd3);

    // One-cycle reset mid-line
    cycle(3'b100, 10, 7, 2'd2);
    rst_n = 1'b0;
    cycle(3'b100, 11, 7, 2'd2);
    check_eq("midrst hve", 32'(obs_hve), 32'h3);
    check_eq("midrst rgb", 32'(obs_rgb), 32'h0);
    check_eq("midrst frame", 32'(obs_frame), 32'h0);
    rst_n = 1'b1;

    // After reset: mode 0 until the next frame start
    sweep_line(10, 2'd3, 2'd3, 0);
    check_eq("postrst x0", 32'(line_rgb[0]), 32'hFFFFFF);
    check_eq("postrst x170", 32'(line_rgb[170]), 32'hFFFF00);
    check_eq("postrst blank", 32'(blank_or), 32'h0);
    check_eq("postrst frame", 32'(obs_frame), 32'd0);

    // Moving bar, frame 1: bar at 4..19
    sweep_line(0, 2'd3, 2'd3, 0);
    check_eq("mbar1 x3", 32'(line_rgb[3]), 32'h000040);
    check_eq("mbar1 x4", 32'(line_rgb[4]), 32'hFFFFFF);
    check_eq("mbar1 x19", 32'(line_rgb[19]), 32'hFFFFFF);
    check_eq("mbar1 x20", 32'(line_rgb[20]), 32'h000040);
    check_eq("mbar1 frame", 32'(obs_frame), 32'd1);

    for (int f = 2; f <= 318; f++) frame_pulse(2'd3);

    // Frame 319: bar at 1276, clipped at the right edge
    sweep_line(0, 2'd3, 2'd3, 0);
    check_eq("mbar319 x1275", 32'(line_rgb[1275]), 32'h000040);
    check_eq("mbar319 x1276", 32'(line_rgb[1276]), 32'hFFFFFF);
    check_eq("mbar319 x1279", 32'(line_rgb[1279]), 32'hFFFFFF);
    check_eq("mbar319 x0", 32'(line_rgb[0]), 32'h000040);

    // Frame 320: bar wrapped back to 0
    sweep_line(0, 2'd3, 2'd3, 0);
    check_eq("mbar320 x0", 32'(line_rgb[0]), 32'hFFFFFF);
    check_eq("mbar320 x15", 32'(line_rgb[15]), 32'hFFFFFF);
    check_eq("mbar320 x16", 32'(line_rgb[16]), 32'h000040);
    check_eq("frame 320", 32'(obs_frame), 32'd320);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
